// File: rtl/ldpc_pkg.sv
// Shared LDPC message widths and the check-node FSM state type.
package ldpc_pkg;
    localparam int MSG_IN_W    = 6;
    localparam int MSG_OUT_W   = 5;
    localparam int MAG_IN_W    = 5;
    localparam int MAG_OUT_W   = 4;
    localparam int MAG_OUT_MAX = 15;

    typedef enum logic {
        COLLECT = 1'b0,
        EMIT    = 1'b1
    } cnu_state_t;
endpackage

// File: rtl/cnu_min_tracker.sv
// Combinational min1/min2/index update for one incoming magnitude.
module cnu_min_tracker
    import ldpc_pkg::*;
#(
    parameter int IDX_W = 3
) (
    input  logic [MAG_IN_W-1:0] min1,
    input  logic [MAG_IN_W-1:0] min2,
    input  logic [IDX_W-1:0]    idx,
    input  logic [MAG_IN_W-1:0] mag,
    input  logic [IDX_W-1:0]    i,
    output logic [MAG_IN_W-1:0] min1_nx,
    output logic [MAG_IN_W-1:0] min2_nx,
    output logic [IDX_W-1:0]    idx_nx
);
    // Strict compares: a tie keeps the first index and pushes the tie into min2.
    always_comb begin
        min1_nx = min1;
        min2_nx = min2;
        idx_nx  = idx;
        if (mag < min1) begin
            min2_nx = min1;
            min1_nx = mag;
            idx_nx  = i;
        end else if (mag < min2) begin
            min2_nx = mag;
        end
    end
endmodule

// File: rtl/cnu_serial.sv
// Serial min-sum check node: collect DC messages, then emit DC extrinsic replies.
// Define CNU_OFFSET_EN for offset min-sum (subtract OFFSET before saturation).
module cnu_serial
    import ldpc_pkg::*;
#(
    parameter int DC     = 6,
    parameter int OFFSET = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [MSG_IN_W-1:0]  in_msg,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [MSG_OUT_W-1:0] out_msg,
    output logic                 out_last,
    output logic                 out_parity
);
    localparam int CW = (DC > 1) ? $clog2(DC) : 1;
    localparam logic [CW-1:0] LAST = CW'(DC - 1);
    localparam logic [MAG_IN_W-1:0] OFF_V = MAG_IN_W'(OFFSET);
`ifdef CNU_OFFSET_EN
    localparam bit OFF_EN = 1'b1;
`else
    localparam bit OFF_EN = 1'b0;
`endif

    cnu_state_t state_q, state_d;
    logic [CW-1:0]       cnt_q;
    logic [DC-1:0]       sign_q;
    logic                tsign_q;
    logic [MAG_IN_W-1:0] min1_q, min2_q, min1_nx, min2_nx;
    logic [CW-1:0]       idx_q, idx_nx;
    logic                in_fire, out_fire;
    logic [MAG_IN_W-1:0] sel_mag, adj_mag;
    logic [MAG_OUT_W-1:0] sat_mag;

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            COLLECT: begin
                in_ready = 1'b1;
                if (in_valid && cnt_q == LAST) state_d = EMIT;
            end
            EMIT: begin
                out_valid = 1'b1;
                if (out_ready && cnt_q == LAST) state_d = COLLECT;
            end
            default: state_d = COLLECT;
        endcase
    end

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    cnu_min_tracker #(.IDX_W(CW)) u_min (
        .min1    (min1_q),
        .min2    (min2_q),
        .idx     (idx_q),
        .mag     (in_msg[MAG_IN_W-1:0]),
        .i       (cnt_q),
        .min1_nx (min1_nx),
        .min2_nx (min2_nx),
        .idx_nx  (idx_nx)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= COLLECT;
            cnt_q   <= '0;
            sign_q  <= '0;
            tsign_q <= 1'b0;
            min1_q  <= '1;
            min2_q  <= '1;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            if (in_fire) begin
                sign_q[cnt_q] <= in_msg[MSG_IN_W-1];
                tsign_q       <= tsign_q ^ in_msg[MSG_IN_W-1];
                min1_q        <= min1_nx;
                min2_q        <= min2_nx;
                idx_q         <= idx_nx;
                cnt_q         <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
            end else if (out_fire) begin
                // Last reply clears the accumulators so the next check starts fresh.
                if (cnt_q == LAST) begin
                    cnt_q   <= '0;
                    tsign_q <= 1'b0;
                    min1_q  <= '1;
                    min2_q  <= '1;
                    idx_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    always_comb begin
        sel_mag = (cnt_q == idx_q) ? min2_q : min1_q;
        adj_mag = sel_mag;
        if (OFF_EN) adj_mag = (sel_mag > OFF_V) ? sel_mag - OFF_V : '0;
        sat_mag = (adj_mag > MAG_IN_W'(MAG_OUT_MAX)) ? MAG_OUT_W'(MAG_OUT_MAX)
                                                     : adj_mag[MAG_OUT_W-1:0];
        out_msg = '0;
        if (state_q == EMIT && sat_mag != '0)
            out_msg = {tsign_q ^ sign_q[cnt_q], sat_mag};
    end

    assign out_last   = (state_q == EMIT) && (cnt_q == LAST);
    assign out_parity = (state_q == EMIT) && tsign_q;
endmodule

// File: tb/tb_cnu_serial.sv
// Randomized and directed bench for cnu_serial against a min-sum reference model.
module tb_cnu_serial;
    localparam int DC     = 6;
    localparam int OFFSET = 1;

    typedef logic [5:0] vec_t [DC];

    logic       clk, rst_n, in_valid, in_ready, out_valid, out_ready, out_last, out_parity;
    logic [5:0] in_msg;
    logic [4:0] out_msg;

    int n_vec  = 0;
    int n_fail = 0;

    cnu_serial #(.DC(DC), .OFFSET(OFFSET)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_msg     (in_msg),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_msg    (out_msg),
        .out_last   (out_last),
        .out_parity (out_parity)
    );

    always #5 clk = ~clk;

    // Reference: each reply is the smallest magnitude among the other DC-1 edges,
    // signed by the XOR of the other edges' signs.
    function automatic logic [4:0] ref_msg(input vec_t m, input int e);
        int mag = 31;
        logic sgn = 1'b0;
        for (int j = 0; j < DC; j++) begin
            if (j != e) begin
                if (int'(m[j][4:0]) < mag) mag = int'(m[j][4:0]);
                sgn ^= m[j][5];
            end
        end
`ifdef CNU_OFFSET_EN
        mag = (mag > OFFSET) ? mag - OFFSET : 0;
`endif
        if (mag > 15) mag = 15;
        if (mag == 0) return 5'b00000;
        return {sgn, 4'(mag)};
    endfunction

    function automatic logic ref_parity(input vec_t m);
        logic p = 1'b0;
        for (int j = 0; j < DC; j++) p ^= m[j][5];
        return p;
    endfunction

    // Entered and left just after a negedge. stall_edge/stall_len force a hold on
    // one edge; rnd_stall adds random holds on every edge.
    task automatic run_check(input vec_t m, input int stall_edge, input int stall_len,
                             input bit rnd_stall, input string tag);
        logic [4:0] exp;
        logic       par;
        int         ns;
        par = ref_parity(m);
        for (int i = 0; i < DC; i++) begin
            in_valid = 1'b1;
            in_msg   = m[i];
            n_vec++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL %s collect[%0d]: in_ready=%b out_valid=%b want 1/0", tag, i, in_ready, out_valid);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        for (int e = 0; e < DC; e++) begin
            exp = ref_msg(m, e);
            ns  = (e == stall_edge) ? stall_len : (rnd_stall ? int'($urandom_range(0, 2)) : 0);
            for (int s = 0; s <= ns; s++) begin
                out_ready = (s == ns);
                if (s < ns) begin
                    in_valid = $urandom_range(0, 1) == 1;
                    in_msg   = 6'($urandom);
                end
                n_vec++;
                if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_msg !== exp ||
                    out_last !== (e == DC - 1) || out_parity !== par) begin
                    n_fail++;
                    $display("FAIL %s emit[%0d] hold%0d: v=%b rdy=%b msg=%b last=%b par=%b want 1 0 %b %b %b",
                             tag, e, s, out_valid, in_ready, out_msg, out_last, out_parity,
                             exp, (e == DC - 1), par);
                end
                @(negedge clk);
                in_valid = 1'b0;
            end
            out_ready = 1'b0;
        end
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s after_last: in_ready=%b out_valid=%b want 1/0", tag, in_ready, out_valid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_msg !== 5'b0 ||
            out_last !== 1'b0 || out_parity !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: rdy=%b v=%b msg=%b last=%b par=%b want 1 0 00000 0 0",
                     in_ready, out_valid, out_msg, out_last, out_parity);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        vec_t v;
        v = '{6'd10, 6'b100011, 6'd7, 6'b100011, 6'd20, 6'd5};
        run_check(v, -1, 0, 1'b0, "tie_min");
        v = '{6'd25, 6'd25, 6'd25, 6'd25, 6'd25, 6'd25};
        run_check(v, -1, 0, 1'b0, "saturate");
        v = '{6'b100001, 6'd4, 6'd4, 6'd4, 6'd4, 6'd4};
        run_check(v, -1, 0, 1'b0, "neg_min");
        v = '{6'd1, 6'd1, 6'd6, 6'd9, 6'd12, 6'd30};
        run_check(v, -1, 0, 1'b0, "small_tie");
        v = '{6'b100000, 6'd0, 6'd31, 6'b111111, 6'd16, 6'd2};
        run_check(v, -1, 0, 1'b0, "zero_edge");
    endtask

    task automatic test_stall();
        vec_t v;
        v = '{6'd10, 6'b100011, 6'd7, 6'b100011, 6'd20, 6'd5};
        run_check(v, 2, 3, 1'b0, "stall");
    endtask

    task automatic test_mid_reset();
        vec_t v;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_msg   = 6'b100000;
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
        v = '{6'd9, 6'b100111, 6'd12, 6'd8, 6'b101110, 6'd11};
        run_check(v, -1, 0, 1'b0, "post_reset");
    endtask

    task automatic test_back_to_back();
        vec_t v;
        for (int k = 0; k < 20; k++) begin
            for (int i = 0; i < DC; i++) begin
                v[i][5]   = 1'($urandom_range(0, 1));
                v[i][4:0] = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 3))
                                                        : 5'($urandom_range(0, 31));
            end
            run_check(v, -1, 0, k[0], "random");
        end
    endtask

    initial begin
        clk       = 1'b0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_msg    = '0;
        out_ready = 1'b0;
        test_reset();
        test_directed();
        test_stall();
        test_mid_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
